axi_master_ctrl: RTL and testbench

- Single-outstanding AXI master that converts simple user commands into AXI write or read bursts.
- Drives the aw/w/b and ar/r channels of the team's axi_slave.
- User side: a command port, a write-data stream, a read-data stream and a completion pulse.
- Sits between the test/DMA logic and axi_slave; one burst in flight at a time, writes and reads never overlap.

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_master_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi_master_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the master FSM state type; used by axi_master_ctrl and axi_slave.
package axi_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 8;
    localparam int AXI_SIZE_BITS = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } mst_state_e;

endpackage

// File: rtl/axi_master_ctrl.sv
// Single-outstanding AXI master: turns one user command into one INCR write or read burst
// and reports completion with a one-cycle done pulse.
module axi_master_ctrl
    import axi_pkg::*;
#(
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS,
    parameter int SIZE_BITS = AXI_SIZE_BITS
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_BITS-1:0]   cmd_addr,
    input  logic [LEN_BITS-1:0]    cmd_len,
    input  logic                   wdata_valid,
    output logic                   wdata_ready,
    input  logic [DATA_BITS-1:0]   wdata,
    output logic                   rdata_valid,
    input  logic                   rdata_ready,
    output logic [DATA_BITS-1:0]   rdata,
    output logic                   rdata_last,
    output logic                   done_valid,
    output logic [1:0]             done_resp,
    output logic                   aw_valid,
    input  logic                   aw_ready,
    output logic [ADDR_BITS-1:0]   aw_addr,
    output logic [LEN_BITS-1:0]    aw_len,
    output logic [SIZE_BITS-1:0]   aw_size,
    output logic [1:0]             aw_burst,
    output logic [3:0]             aw_cache,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [DATA_BITS-1:0]   w_data,
    output logic                   w_last,
    output logic [DATA_BITS/8-1:0] w_strb,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [1:0]             b_resp,
    output logic                   ar_valid,
    input  logic                   ar_ready,
    output logic [ADDR_BITS-1:0]   ar_addr,
    output logic [LEN_BITS-1:0]    ar_len,
    output logic [SIZE_BITS-1:0]   ar_size,
    output logic [1:0]             ar_burst,
    output logic [3:0]             ar_cache,
    input  logic                   r_valid,
    output logic                   r_ready,
    input  logic [DATA_BITS-1:0]   r_data,
    input  logic                   r_last,
    input  logic [1:0]             r_resp
);

    localparam int STRB_BITS = DATA_BITS / 8;
    localparam logic [SIZE_BITS-1:0] AX_SIZE = SIZE_BITS'($clog2(STRB_BITS));

    mst_state_e            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  done_valid_q, done_valid_d;
    logic [1:0]            done_resp_q, done_resp_d;
    logic [ADDR_BITS-1:0]  aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [LEN_BITS-1:0]   aw_len_q, aw_len_d, ar_len_q, ar_len_d;
    logic [LEN_BITS-1:0]   beat_cnt_q, beat_cnt_d;
    logic [1:0]            err_q, err_d;
    logic                  cnt_err_q, cnt_err_d;
    logic                  w_fire_s, r_fire_s, r_cnt_bad_s;

    // Next-state and next-output computation for the burst FSM.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        aw_valid_d   = aw_valid_q;
        ar_valid_d   = ar_valid_q;
        b_ready_d    = b_ready_q;
        done_valid_d = 1'b0;
        done_resp_d  = done_resp_q;
        aw_addr_d    = aw_addr_q;
        aw_len_d     = aw_len_q;
        ar_addr_d    = ar_addr_q;
        ar_len_d     = ar_len_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        cnt_err_d    = cnt_err_q;
        w_fire_s     = (state_q == ST_WR_DATA) && wdata_valid && w_ready;
        r_fire_s     = (state_q == ST_RD_DATA) && r_valid && rdata_ready;
        r_cnt_bad_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    beat_cnt_d  = {LEN_BITS{1'b0}};
                    err_d       = RESP_OKAY;
                    cnt_err_d   = 1'b0;
                    if (cmd_write) begin
                        aw_addr_d  = cmd_addr;
                        aw_len_d   = cmd_len;
                        aw_valid_d = 1'b1;
                        state_d    = ST_WR_ADDR;
                    end else begin
                        ar_addr_d  = cmd_addr;
                        ar_len_d   = cmd_len;
                        ar_valid_d = 1'b1;
                        state_d    = ST_RD_ADDR;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                if (aw_ready) begin
                    aw_valid_d = 1'b0;
                    state_d    = ST_WR_DATA;
                end else begin
                    aw_valid_d = 1'b1;
                end
            end
            ST_WR_DATA: begin
                if (w_fire_s && (beat_cnt_q == aw_len_q)) begin
                    b_ready_d = 1'b1;
                    state_d   = ST_WR_RESP;
                end else if (w_fire_s) begin
                    beat_cnt_d = beat_cnt_q + {{(LEN_BITS-1){1'b0}}, 1'b1};
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            ST_WR_RESP: begin
                if (b_valid) begin
                    b_ready_d    = 1'b0;
                    done_resp_d  = b_resp;
                    done_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    b_ready_d = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = ST_RD_DATA;
                end else begin
                    ar_valid_d = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (r_fire_s) begin
                    // Early r_last or a missing r_last at len are both burst-length violations.
                    r_cnt_bad_s = (r_last != (beat_cnt_q == ar_len_q));
                    if ((r_resp != RESP_OKAY) && (err_q == RESP_OKAY)) begin
                        err_d = r_resp;
                    end else begin
                        err_d = err_q;
                    end
                    if (beat_cnt_q != ar_len_q) begin
                        beat_cnt_d = beat_cnt_q + {{(LEN_BITS-1){1'b0}}, 1'b1};
                    end else begin
                        beat_cnt_d = beat_cnt_q;
                    end
                    cnt_err_d = cnt_err_q || r_cnt_bad_s;
                    if (r_last) begin
                        done_valid_d = 1'b1;
                        state_d      = ST_DONE;
                        if (cnt_err_q || r_cnt_bad_s) begin
                            done_resp_d = RESP_SLVERR;
                        end else if (err_q != RESP_OKAY) begin
                            done_resp_d = err_q;
                        end else begin
                            done_resp_d = r_resp;
                        end
                    end else begin
                        state_d = ST_RD_DATA;
                    end
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                aw_valid_d  = 1'b0;
                ar_valid_d  = 1'b0;
                b_ready_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output flops with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            aw_valid_q   <= 1'b0;
            ar_valid_q   <= 1'b0;
            b_ready_q    <= 1'b0;
            done_valid_q <= 1'b0;
            done_resp_q  <= RESP_OKAY;
            aw_addr_q    <= {ADDR_BITS{1'b0}};
            aw_len_q     <= {LEN_BITS{1'b0}};
            ar_addr_q    <= {ADDR_BITS{1'b0}};
            ar_len_q     <= {LEN_BITS{1'b0}};
            beat_cnt_q   <= {LEN_BITS{1'b0}};
            err_q        <= RESP_OKAY;
            cnt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            aw_valid_q   <= aw_valid_d;
            ar_valid_q   <= ar_valid_d;
            b_ready_q    <= b_ready_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
            aw_addr_q    <= aw_addr_d;
            aw_len_q     <= aw_len_d;
            ar_addr_q    <= ar_addr_d;
            ar_len_q     <= ar_len_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            cnt_err_q    <= cnt_err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign done_valid = done_valid_q;
    assign done_resp  = done_resp_q;
    assign aw_valid   = aw_valid_q;
    assign aw_addr    = aw_addr_q;
    assign aw_len     = aw_len_q;
    assign aw_size    = AX_SIZE;
    assign aw_burst   = BURST_INCR;
    assign aw_cache   = 4'b0000;
    assign ar_valid   = ar_valid_q;
    assign ar_addr    = ar_addr_q;
    assign ar_len     = ar_len_q;
    assign ar_size    = AX_SIZE;
    assign ar_burst   = BURST_INCR;
    assign ar_cache   = 4'b0000;
    assign b_ready    = b_ready_q;
    assign w_strb     = {STRB_BITS{1'b1}};

    // Data beats pass straight through, but only while their burst phase is active.
    assign w_valid     = (state_q == ST_WR_DATA) && wdata_valid;
    assign wdata_ready = (state_q == ST_WR_DATA) && w_ready;
    assign w_data      = (state_q == ST_WR_DATA) ? wdata : {DATA_BITS{1'b0}};
    assign w_last      = (state_q == ST_WR_DATA) && (beat_cnt_q == aw_len_q);
    assign r_ready     = (state_q == ST_RD_DATA) && rdata_ready;
    assign rdata_valid = (state_q == ST_RD_DATA) && r_valid;
    assign rdata       = (state_q == ST_RD_DATA) ? r_data : {DATA_BITS{1'b0}};
    assign rdata_last  = (state_q == ST_RD_DATA) && r_last;

endmodule

// File: tb/tb_axi_master_ctrl.sv
// Directed bench for axi_master_ctrl; a behavioural slave memory is driven inline.
module tb_axi_master_ctrl;

    logic        aclk;
    logic        areset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready, rdata_last;
    logic [31:0] rdata;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_cache;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_cache;
    logic        r_valid, r_ready, r_last;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_vec  [0:7];
    logic [31:0] exp_vec [0:7];

    axi_master_ctrl dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .done_valid(done_valid), .done_resp(done_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .w_strb(w_strb), .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .r_resp(r_resp)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        @(negedge aclk);
        cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0;
        #1;
        check("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
        if (wr) begin
            check("aw_valid_lat1", {63'd0, aw_valid}, 64'd1);
            check("aw_addr", {32'd0, aw_addr}, {32'd0, addr});
            check("aw_len", {56'd0, aw_len}, {56'd0, len});
            check("aw_size", {61'd0, aw_size}, 64'd2);
            check("aw_burst", {62'd0, aw_burst}, 64'd1);
            check("aw_cache", {60'd0, aw_cache}, 64'd0);
            check("w_strb", {60'd0, w_strb}, 64'hF);
        end else begin
            check("ar_valid_lat1", {63'd0, ar_valid}, 64'd1);
            check("ar_addr", {32'd0, ar_addr}, {32'd0, addr});
            check("ar_len", {56'd0, ar_len}, {56'd0, len});
            check("ar_size", {61'd0, ar_size}, 64'd2);
            check("ar_burst", {62'd0, ar_burst}, 64'd1);
            check("ar_cache", {60'd0, ar_cache}, 64'd0);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int aw_stall,
                            input bit toggle, input logic [1:0] bresp);
        int  idx;
        int  c;
        bit  hs;
        issue_cmd(1'b1, addr, len);
        wdata_valid = 1'b1; wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < aw_stall; i++) begin
            #1;
            check("aw_hold_valid", {63'd0, aw_valid}, 64'd1);
            check("aw_hold_addr", {32'd0, aw_addr}, {32'd0, addr});
            check("aw_hold_len", {56'd0, aw_len}, {56'd0, len});
            check("wdata_ready_early", {63'd0, wdata_ready}, 64'd0);
            check("w_valid_early", {63'd0, w_valid}, 64'd0);
            @(negedge aclk);
        end
        aw_ready = 1'b1;
        @(negedge aclk);
        aw_ready = 1'b0;
        idx = 0; c = 0;
        while (idx <= int'(len) && c < 64) begin
            wdata_valid = toggle ? (c % 2 == 0) : 1'b1;
            wdata = wr_vec[idx];
            #1;
            check("aw_valid_drop", {63'd0, aw_valid}, 64'd0);
            check("w_valid", {63'd0, w_valid}, {63'd0, wdata_valid});
            check("w_last", {63'd0, w_last}, {63'd0, (idx == int'(len))});
            check("wdata_ready", {63'd0, wdata_ready}, 64'd1);
            hs = wdata_valid;
            if (hs) begin
                check("w_data", {32'd0, w_data}, {32'd0, wr_vec[idx]});
                mem[addr + 32'(4 * idx)] = w_data;
            end
            @(negedge aclk);
            if (hs) idx++;
            c++;
        end
        check("w_beats", 64'(idx), 64'(int'(len) + 1));
        wdata_valid = 1'b0;
        #1;
        check("b_ready", {63'd0, b_ready}, 64'd1);
        check("wdata_ready_resp", {63'd0, wdata_ready}, 64'd0);
        b_valid = 1'b1; b_resp = bresp;
        @(negedge aclk);
        b_valid = 1'b0; b_resp = 2'b00;
        #1;
        check("wr_done_valid", {63'd0, done_valid}, 64'd1);
        check("wr_done_resp", {62'd0, done_resp}, {62'd0, bresp});
        check("wr_cmd_ready_done", {63'd0, cmd_ready}, 64'd0);
        @(negedge aclk);
        check("wr_done_pulse", {63'd0, done_valid}, 64'd0);
        check("wr_cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int nb,
                           input int stall_at, input int err_at, input logic [1:0] err_val,
                           input logic [1:0] exp_resp);
        int          idx;
        int          c;
        int          stalls;
        logic [31:0] a;
        issue_cmd(1'b0, addr, len);
        ar_ready = 1'b1;
        @(negedge aclk);
        ar_ready = 1'b0;
        idx = 0; c = 0; stalls = 0;
        while (idx < nb && c < 64) begin
            a = addr + 32'(4 * idx);
            r_valid = 1'b1;
            r_data  = mem.exists(a) ? mem[a] : 32'hBAD0_0000;
            r_last  = (idx == nb - 1);
            r_resp  = (idx == err_at) ? err_val : 2'b00;
            rdata_ready = !(idx == stall_at && stalls < 3);
            #1;
            check("ar_valid_drop", {63'd0, ar_valid}, 64'd0);
            check("rdata_valid", {63'd0, rdata_valid}, 64'd1);
            check("rdata", {32'd0, rdata}, {32'd0, exp_vec[idx]});
            check("rdata_last", {63'd0, rdata_last}, {63'd0, (idx == nb - 1)});
            check("r_ready", {63'd0, r_ready}, {63'd0, rdata_ready});
            @(negedge aclk);
            if (rdata_ready) idx++;
            else stalls++;
            c++;
        end
        check("r_beats", 64'(idx), 64'(nb));
        r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00; rdata_ready = 1'b0;
        #1;
        check("rd_done_valid", {63'd0, done_valid}, 64'd1);
        check("rd_done_resp", {62'd0, done_resp}, {62'd0, exp_resp});
        check("rdata_valid_done", {63'd0, rdata_valid}, 64'd0);
        @(negedge aclk);
        check("rd_done_pulse", {63'd0, done_valid}, 64'd0);
        check("rd_cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
    endtask

    initial begin
        aclk = 1'b0; areset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0;
        wdata_valid = 1'b0; wdata = 32'h0; rdata_ready = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b1; b_valid = 1'b0; b_resp = 2'b00;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = 32'h0; r_last = 1'b0; r_resp = 2'b00;
        repeat (2) @(negedge aclk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_aw_valid", {63'd0, aw_valid}, 64'd0);
        check("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
        check("rst_b_ready", {63'd0, b_ready}, 64'd0);
        check("rst_done_valid", {63'd0, done_valid}, 64'd0);
        check("rst_done_resp", {62'd0, done_resp}, 64'd0);
        check("rst_aw_addr", {32'd0, aw_addr}, 64'd0);
        check("rst_ar_len", {56'd0, ar_len}, 64'd0);
        areset_n = 1'b1;
        @(negedge aclk);

        // Basic 4-beat write and read-back.
        wr_vec[0] = 32'hA0; wr_vec[1] = 32'hA1; wr_vec[2] = 32'hA2; wr_vec[3] = 32'hA3;
        do_write(32'h10, 8'd3, 0, 1'b0, 2'b00);
        exp_vec[0] = 32'hA0; exp_vec[1] = 32'hA1; exp_vec[2] = 32'hA2; exp_vec[3] = 32'hA3;
        do_read(32'h10, 8'd3, 4, -1, -1, 2'b00, 2'b00);

        // Single-beat burst.
        wr_vec[0] = 32'hDEADBEEF;
        do_write(32'h3FF, 8'd0, 0, 1'b0, 2'b00);
        exp_vec[0] = 32'hDEADBEEF;
        do_read(32'h3FF, 8'd0, 1, -1, -1, 2'b00, 2'b00);

        // aw_ready stall, toggling write valid, read back-pressure.
        wr_vec[0] = 32'hB0; wr_vec[1] = 32'hB1; wr_vec[2] = 32'hB2; wr_vec[3] = 32'hB3;
        do_write(32'h20, 8'd3, 5, 1'b1, 2'b00);
        exp_vec[0] = 32'hB0; exp_vec[1] = 32'hB1; exp_vec[2] = 32'hB2; exp_vec[3] = 32'hB3;
        do_read(32'h20, 8'd3, 4, 2, -1, 2'b00, 2'b00);

        // SLVERR on beat 2 plus early r_last on beat 3.
        mem[32'h100] = 32'hC0; mem[32'h104] = 32'hC1; mem[32'h108] = 32'hC2;
        exp_vec[0] = 32'hC0; exp_vec[1] = 32'hC1; exp_vec[2] = 32'hC2;
        do_read(32'h100, 8'd3, 3, -1, 1, 2'b10, 2'b10);

        // Overrun: len=1 but slave delivers three beats, all OKAY.
        mem[32'h180] = 32'hD0; mem[32'h184] = 32'hD1; mem[32'h188] = 32'hD2;
        exp_vec[0] = 32'hD0; exp_vec[1] = 32'hD1; exp_vec[2] = 32'hD2;
        do_read(32'h180, 8'd1, 3, -1, -1, 2'b00, 2'b10);

        // Reset during the second write beat.
        issue_cmd(1'b1, 32'h200, 8'd3);
        aw_ready = 1'b1;
        @(negedge aclk);
        aw_ready = 1'b0;
        wdata_valid = 1'b1; wdata = 32'h77;
        @(negedge aclk);
        wdata = 32'h78;
        #2 areset_n = 1'b0;
        #1;
        check("rstmid_w_valid", {63'd0, w_valid}, 64'd0);
        check("rstmid_wdata_ready", {63'd0, wdata_ready}, 64'd0);
        check("rstmid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rstmid_aw_valid", {63'd0, aw_valid}, 64'd0);
        check("rstmid_b_ready", {63'd0, b_ready}, 64'd0);
        check("rstmid_done_valid", {63'd0, done_valid}, 64'd0);
        wdata_valid = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("rstmid_no_done", {63'd0, done_valid}, 64'd0);
        end

        // Fresh len=1 write after reset, then read with a DECERR latched on beat 1.
        wr_vec[0] = 32'h11; wr_vec[1] = 32'h22;
        do_write(32'h40, 8'd1, 0, 1'b0, 2'b00);
        exp_vec[0] = 32'h11; exp_vec[1] = 32'h22;
        do_read(32'h40, 8'd1, 2, -1, 0, 2'b11, 2'b11);

        // Write response is forwarded as-is.
        wr_vec[0] = 32'h55;
        do_write(32'h80, 8'd0, 2, 1'b0, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
